seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 20 ++
 rtl/mul_add_stage.sv | 17 +
 rtl/seq_multiplier.sv | 87 ++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared op and FSM state encodings for the sequential multiplier and the ALU decode
package seq_multiplier_pkg;
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;
  function automatic logic op_a_signed(input op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU);
  endfunction
  function automatic logic op_b_signed(input op_e o);
    return o == OP_MULH;
  endfunction
endpackage

// File: rtl/mul_add_stage.sv
// mul_add_stage: combinational ripple-carry adder built from full-adder cells
module mul_add_stage #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic [W:0] w_c;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_cout = w_c[W];
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add sequential multiplier supporting MUL/MULH/MULHSU/MULHU
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] FIN = CW'(WIDTH);
  state_e             r_state, w_state_nxt;
  op_e                r_op;
  logic               r_neg, r_busy, r_done;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand, r_result;
  logic [2*WIDTH-1:0] r_acc;
  op_e                w_op;
  logic               w_a_neg, w_b_neg, w_busy_nxt, w_done_nxt, w_cout;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
  assign w_op    = op_e'(op);
  assign w_a_neg = a[WIDTH-1] & op_a_signed(w_op);
  assign w_b_neg = b[WIDTH-1] & op_b_signed(w_op);
  assign w_a_mag = w_a_neg ? ~a + 1'b1 : a;
  assign w_b_mag = w_b_neg ? ~b + 1'b1 : b;
  mul_add_stage #(.W(WIDTH + 1)) u_add (
    .i_a    ({1'b0, r_acc[2*WIDTH-1:WIDTH]}),
    .i_b    ({1'b0, r_acc[0] ? r_mcand : '0}),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );
  assign w_acc_nxt = {w_sum[WIDTH] | w_cout, w_sum[WIDTH-1:0], r_acc[WIDTH-1:1]};
  assign w_prod    = r_neg ? ~r_acc + 1'b1 : r_acc;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  // next state: RUN spends WIDTH iteration cycles plus one finalize cycle
  always_comb
    w_state_nxt = (r_state == S_IDLE) ? (start ? S_RUN : S_IDLE) :
                  (r_state == S_RUN)  ? ((r_cnt == FIN) ? S_DONE : S_RUN) : S_IDLE;
  // next-cycle status outputs, registered below
  always_comb begin
    w_busy_nxt = w_state_nxt != S_IDLE;
    w_done_nxt = w_state_nxt == S_DONE;
  end
  // operand capture, shift-add iterations, sign fixup and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (r_state == S_IDLE && start) begin
        r_op    <= w_op;
        r_neg   <= w_a_neg ^ w_b_neg;
        r_mcand <= w_a_mag;
        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
        r_cnt   <= '0;
      end else if (r_state == S_RUN && r_cnt != FIN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_RUN) begin
        r_result <= (r_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
      end
    end
  end
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
endmodule
